// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - ALU control codes, RV32I opcodes and issue-stage types
`timescale 1ns/1ps
package alu_issue_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_BEQ  = 4'b1001;
  localparam logic [3:0] ALU_BNE  = 4'b1010;
  localparam logic [3:0] ALU_BLT  = 4'b1011;
  localparam logic [3:0] ALU_BGE  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  // Reserved for the ALU; the issue stage never produces it.
  localparam logic [3:0] ALU_BGT  = 4'b1110;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Shared OP / OP-IMM table; alt selects SUB/SRA over ADD/SRL.
  function automatic logic [3:0] arith_code(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    code = ALU_ADD;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_ctl_dec.sv
// rtl/alu_ctl_dec.sv - combinational RV32I decode to ALU control code and operands
`timescale 1ns/1ps
module alu_ctl_dec
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic [3:0]      ctl,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            is_branch,
  output logic            br_uns,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_shift;
  logic       imm_legal;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  // Register indices are resolved in ID; only the opcode/funct fields matter here.
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  assign is_shift  = (f3 == 3'b001) || (f3 == 3'b101);
  assign imm_legal = !is_shift || (f7 == F7_ZERO) || ((f3 == 3'b101) && (f7 == F7_ALT));

  always_comb begin
    ctl       = ALU_ADD;
    op_a      = '0;
    op_b      = '0;
    is_branch = 1'b0;
    br_uns    = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        if ((f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))) begin
          ctl  = arith_code(f3, f7[5]);
          op_a = rs1_data;
          op_b = rs2_data;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (imm_legal) begin
          ctl  = arith_code(f3, is_shift && f7[5]);
          op_a = rs1_data;
          op_b = is_shift ? {{(XLEN-5){1'b0}}, instr[24:20]} : imm;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LOAD, OPC_STORE: begin
        op_a = rs1_data;
        op_b = imm;
      end
      OPC_LUI: begin
        op_b = imm;
      end
      OPC_AUIPC: begin
        op_a = pc;
        op_b = imm;
      end
      OPC_JAL, OPC_JALR: begin
        op_a = pc;
        op_b = XLEN'(4);
      end
      OPC_BRANCH: begin
        if (f3[2:1] == 2'b01) begin
          illegal = 1'b1;
        end else begin
          is_branch = 1'b1;
          br_uns    = f3[1];
          op_a      = rs1_data;
          op_b      = rs2_data;
          case (f3)
            3'b000:          ctl = ALU_BEQ;
            3'b001:          ctl = ALU_BNE;
            3'b100, 3'b110:  ctl = ALU_BLT;
            default:         ctl = ALU_BGE;
          endcase
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID->EX issue stage: decode, main register and 1-entry skid buffer
`timescale 1ns/1ps
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [3:0]      ex_alu_ctl,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic            ex_is_branch,
  output logic            ex_br_uns,
  output logic            ex_illegal
);

  typedef struct packed {
    logic [3:0]      ctl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            is_branch;
    logic            br_uns;
    logic            illegal;
  } entry_t;

  occ_e   state_q, state_d;
  entry_t dec_entry, main_q, skid_q;
  logic   id_ready_q;
  logic   accept, retire;
  logic   load_main, main_from_skid, load_skid;

  alu_ctl_dec #(.XLEN(XLEN)) u_dec (
    .instr     (id_instr),
    .pc        (id_pc),
    .rs1_data  (id_rs1_data),
    .rs2_data  (id_rs2_data),
    .imm       (id_imm),
    .ctl       (dec_entry.ctl),
    .op_a      (dec_entry.op_a),
    .op_b      (dec_entry.op_b),
    .is_branch (dec_entry.is_branch),
    .br_uns    (dec_entry.br_uns),
    .illegal   (dec_entry.illegal)
  );

  // A flush-cycle offer is discarded, so it never counts as an accept.
  assign accept = id_valid && id_ready_q && !flush;
  assign retire = ex_valid && ex_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            state_d   = OCC_MAIN;
            load_main = 1'b1;
          end
        end
        OCC_MAIN: begin
          if (accept && retire) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = OCC_FULL;
            load_skid = 1'b1;
          end else if (retire) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (retire) begin
            state_d        = OCC_MAIN;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      id_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      id_ready_q <= (state_d != OCC_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= dec_entry;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec_entry;
      end
    end
  end

  assign id_ready     = id_ready_q;
  assign ex_valid     = (state_q != OCC_EMPTY);
  assign ex_alu_ctl   = main_q.ctl;
  assign ex_op_a      = main_q.op_a;
  assign ex_op_b      = main_q.op_b;
  assign ex_is_branch = main_q.is_branch;
  assign ex_br_uns    = main_q.br_uns;
  assign ex_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed vector bench for alu_issue_stage
`timescale 1ns/1ps
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [31:0] id_instr = '0;
  logic [31:0] id_pc = '0;
  logic [31:0] id_rs1_data = '0;
  logic [31:0] id_rs2_data = '0;
  logic [31:0] id_imm = '0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [3:0]  ex_alu_ctl;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic        ex_is_branch;
  logic        ex_br_uns;
  logic        ex_illegal;

  int total = 0;
  int bad = 0;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_rs1_data  (id_rs1_data),
    .id_rs2_data  (id_rs2_data),
    .id_imm       (id_imm),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_alu_ctl   (ex_alu_ctl),
    .ex_op_a      (ex_op_a),
    .ex_op_b      (ex_op_b),
    .ex_is_branch (ex_is_branch),
    .ex_br_uns    (ex_br_uns),
    .ex_illegal   (ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic        uns;
    logic        ill;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  localparam logic [31:0] ADD_X3 = 32'h002081B3;
  localparam logic [31:0] SUB_X3 = 32'h402081B3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    id_instr    = instr;
    id_pc       = pc;
    id_rs1_data = rs1;
    id_rs2_data = rs2;
    id_imm      = imm;
    id_valid    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    //           instr         pc          rs1         rs2         imm          ctl    a             b             br    uns   ill
    vecs[0]  = '{32'h002081B3, 32'h0,      32'd5,      32'd7,      32'h0,       4'h0, 32'd5,        32'd7,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h402081B3, 32'h0,      32'd5,      32'd7,      32'h0,       4'h8, 32'd5,        32'd7,        1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h40335293, 32'h0,      32'd5,      32'd7,      32'h403,     4'hD, 32'd5,        32'd3,        1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h40331293, 32'h0,      32'd5,      32'd7,      32'h403,     4'h0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
    vecs[4]  = '{32'h0020F063, 32'h0,      32'd5,      32'd7,      32'h0,       4'hC, 32'd5,        32'd7,        1'b1, 1'b1, 1'b0};
    vecs[5]  = '{32'h0020A063, 32'h0,      32'd5,      32'd7,      32'h0,       4'h0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
    vecs[6]  = '{32'h000000EF, 32'h100,    32'd5,      32'd7,      32'h0,       4'h0, 32'h100,      32'd4,        1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h123450B7, 32'h0,      32'd5,      32'd7,      32'h12345000,4'h0, 32'd0,        32'h12345000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h00001097, 32'h200,    32'd5,      32'd7,      32'h1000,    4'h0, 32'h200,      32'h1000,     1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h00812083, 32'h0,      32'h40,     32'd7,      32'd8,       4'h0, 32'h40,       32'd8,        1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h0020C063, 32'h0,      32'd5,      32'd7,      32'h0,       4'hB, 32'd5,        32'd7,        1'b1, 1'b0, 1'b0};
    vecs[11] = '{32'h00209063, 32'h0,      32'd5,      32'd7,      32'h0,       4'hA, 32'd5,        32'd7,        1'b1, 1'b0, 1'b0};
    vecs[12] = '{32'h0020B1B3, 32'h0,      32'd5,      32'd7,      32'h0,       4'h3, 32'd5,        32'd7,        1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'h4020C1B3, 32'h0,      32'd5,      32'd7,      32'h0,       4'h0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
    vecs[14] = '{32'h00000000, 32'h0,      32'd5,      32'd7,      32'h0,       4'h0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
    vecs[15] = '{32'hFFF17093, 32'h0,      32'd5,      32'd7,      32'hFFFFFFFF,4'h7, 32'd5,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{32'h00335293, 32'h0,      32'd5,      32'd7,      32'h3,       4'h5, 32'd5,        32'd3,        1'b0, 1'b0, 1'b0};
    vecs[17] = '{32'h4020D1B3, 32'h0,      32'd5,      32'd7,      32'h0,       4'hD, 32'd5,        32'd7,        1'b0, 1'b0, 1'b0};
    vecs[18] = '{32'h0020E063, 32'h0,      32'd5,      32'd7,      32'h0,       4'hB, 32'd5,        32'd7,        1'b1, 1'b1, 1'b0};
    vecs[19] = '{32'h000080E7, 32'h300,    32'd5,      32'd7,      32'h0,       4'h0, 32'h300,      32'd4,        1'b0, 1'b0, 1'b0};
    vecs[20] = '{32'h00112423, 32'h0,      32'h80,     32'd7,      32'd8,       4'h0, 32'h80,       32'd8,        1'b0, 1'b0, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    chk("reset id_ready", 32'(id_ready), 32'd1);
    chk("reset ctl", 32'(ex_alu_ctl), 32'd0);
    chk("reset op_a", ex_op_a, 32'd0);
    chk("reset op_b", ex_op_b, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Decode table, issued back to back with EX always ready.
    ex_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      @(negedge clk);
      chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'd1);
      chk($sformatf("v%0d ctl", i), 32'(ex_alu_ctl), 32'(vecs[i].ctl));
      chk($sformatf("v%0d op_a", i), ex_op_a, vecs[i].a);
      chk($sformatf("v%0d op_b", i), ex_op_b, vecs[i].b);
      chk($sformatf("v%0d is_branch", i), 32'(ex_is_branch), 32'(vecs[i].br));
      chk($sformatf("v%0d br_uns", i), 32'(ex_br_uns), 32'(vecs[i].uns));
      chk($sformatf("v%0d illegal", i), 32'(ex_illegal), 32'(vecs[i].ill));
    end
    id_valid = 1'b0;
    @(negedge clk);
    chk("drain ex_valid", 32'(ex_valid), 32'd0);

    // Three back-to-back offers with EX stalled for two cycles.
    ex_ready = 1'b0;
    drive(ADD_X3, 32'h0, 32'd11, 32'd1, 32'h0);
    @(negedge clk);
    chk("stall1 id_ready", 32'(id_ready), 32'd1);
    chk("stall1 op_a", ex_op_a, 32'd11);
    drive(ADD_X3, 32'h0, 32'd22, 32'd2, 32'h0);
    @(negedge clk);
    chk("stall2 id_ready", 32'(id_ready), 32'd0);
    chk("stall2 ex_valid", 32'(ex_valid), 32'd1);
    chk("stall2 op_a held", ex_op_a, 32'd11);
    drive(ADD_X3, 32'h0, 32'd33, 32'd3, 32'h0);
    ex_ready = 1'b1;
    @(negedge clk);
    chk("skid op_a", ex_op_a, 32'd22);
    chk("skid op_b", ex_op_b, 32'd2);
    chk("skid id_ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    chk("third op_a", ex_op_a, 32'd33);
    chk("third ex_valid", 32'(ex_valid), 32'd1);
    id_valid = 1'b0;
    @(negedge clk);
    chk("stall drain ex_valid", 32'(ex_valid), 32'd0);

    // Flush while FULL with an offer in the flush cycle.
    ex_ready = 1'b0;
    drive(ADD_X3, 32'h0, 32'd44, 32'd0, 32'h0);
    @(negedge clk);
    drive(ADD_X3, 32'h0, 32'd55, 32'd0, 32'h0);
    @(negedge clk);
    chk("pre-flush id_ready", 32'(id_ready), 32'd0);
    flush = 1'b1;
    drive(ADD_X3, 32'h0, 32'd66, 32'd0, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    id_valid = 1'b0;
    chk("flush full ex_valid", 32'(ex_valid), 32'd0);
    chk("flush full id_ready", 32'(id_ready), 32'd1);
    ex_ready = 1'b1;
    @(negedge clk);
    chk("flush full stays empty", 32'(ex_valid), 32'd0);

    // Flush while MAIN with an acceptable offer in the flush cycle.
    ex_ready = 1'b0;
    drive(ADD_X3, 32'h0, 32'd77, 32'd0, 32'h0);
    @(negedge clk);
    flush = 1'b1;
    drive(ADD_X3, 32'h0, 32'd88, 32'd0, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    id_valid = 1'b0;
    chk("flush main ex_valid", 32'(ex_valid), 32'd0);
    chk("flush main id_ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    chk("flush main stays empty", 32'(ex_valid), 32'd0);
    ex_ready = 1'b1;
    drive(ADD_X3, 32'h0, 32'd99, 32'd0, 32'h0);
    @(negedge clk);
    id_valid = 1'b0;
    chk("post-flush ex_valid", 32'(ex_valid), 32'd1);
    chk("post-flush op_a", ex_op_a, 32'd99);
    @(negedge clk);

    // Asynchronous reset while FULL.
    ex_ready = 1'b0;
    drive(SUB_X3, 32'h0, 32'h123, 32'h5, 32'h0);
    @(negedge clk);
    drive(SUB_X3, 32'h0, 32'h456, 32'h6, 32'h0);
    @(negedge clk);
    chk("pre-reset ctl", 32'(ex_alu_ctl), 32'h8);
    #2;
    rst_n = 1'b0;
    id_valid = 1'b0;
    #1;
    chk("async reset ex_valid", 32'(ex_valid), 32'd0);
    chk("async reset id_ready", 32'(id_ready), 32'd1);
    chk("async reset ctl", 32'(ex_alu_ctl), 32'd0);
    chk("async reset op_a", ex_op_a, 32'd0);
    chk("async reset op_b", ex_op_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ex_ready = 1'b1;
    drive(ADD_X3, 32'h0, 32'hABC, 32'h1, 32'h0);
    @(negedge clk);
    id_valid = 1'b0;
    chk("post-reset ex_valid", 32'(ex_valid), 32'd1);
    chk("post-reset op_a", ex_op_a, 32'hABC);
    @(negedge clk);
    chk("post-reset drain", 32'(ex_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
